// File: rtl/jpeg_input.sv
// jpeg_input: encoder-side pixel front end.
// Takes a raster-order RGB stream, converts each pixel to level-shifted YCbCr,
// buffers one 8-line strip in an internal RAM and replays it as 8x8 blocks of
// 64 (idx, data, id) beats. A final EOF beat closes every image.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-low reset
//   img_start_i             start/abort pulse; img_width_i/img_height_i/img_mode_i
//                           are held stable by the source until idle_o
//   inport_*                pixel input (valid/accept handshake, r/g/b 8 bits each)
//   outport_*               block beat output (valid/accept handshake)
//   idle_o                  high while no image is in progress
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for img_start_i
// FILL  | accepting pixels into the strip RAM
// EMIT  | replaying the strip as 8x8 blocks
// EOF   | presenting the end-of-image beat until accepted
module jpeg_input #(
    parameter int MAX_WIDTH = 1024,
    parameter int ADDR_W    = 13
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        img_start_i,
    input  logic [15:0] img_width_i,
    input  logic [15:0] img_height_i,
    input  logic [1:0]  img_mode_i,
    input  logic        inport_valid_i,
    input  logic [7:0]  inport_r_i,
    input  logic [7:0]  inport_g_i,
    input  logic [7:0]  inport_b_i,
    output logic        inport_accept_o,
    output logic        outport_valid_o,
    output logic [31:0] outport_data_o,
    output logic [5:0]  outport_idx_o,
    output logic [31:0] outport_id_o,
    input  logic        outport_accept_i,
    output logic        idle_o
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT, S_EOF} state_t;

    localparam logic [15:0]       LP_MAXW   = 16'(MAX_WIDTH);
    localparam logic [ADDR_W-1:0] LP_MAXW_A = ADDR_W'(MAX_WIDTH);

    state_t      r_state;
    logic        r_accept, r_idle;
    logic        r_out_valid;
    logic [31:0] r_out_data, r_out_id;
    logic [5:0]  r_out_idx;
    logic [15:0] r_x, r_y;
    logic [2:0]  r_last_row;
    logic [13:0] r_strip;
    logic        r_last_strip;
    // read-issue counters
    logic [15:0] r_bx;
    logic [1:0]  r_comp;
    logic [5:0]  r_idx;
    logic        r_iss;
    // beat whose RAM word is in r_q
    logic        r_p1_valid;
    logic [1:0]  r_p1_comp;
    logic [5:0]  r_p1_idx;
    logic [15:0] r_p1_bx;
    logic [23:0] r_q;
    logic [23:0] r_mem [0:8*MAX_WIDTH-1];

    // Cr of pure red and Cb of pure blue round to +128, so results are clamped.
    function automatic logic [7:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127)       return 8'h7F;
        else if (v < -32'sd128) return 8'h80;
        else                    return v[7:0];
    endfunction

    logic signed [31:0] w_r, w_g, w_b, w_y_s, w_cb_s, w_cr_s;
    assign w_r    = {24'd0, inport_r_i};
    assign w_g    = {24'd0, inport_g_i};
    assign w_b    = {24'd0, inport_b_i};
    assign w_y_s  = ((32'sd1225 * w_r + 32'sd2404 * w_g + 32'sd467 * w_b + 32'sd2048) >>> 12) - 32'sd128;
    assign w_cb_s = (32'sd2048 * w_b - 32'sd691 * w_r - 32'sd1357 * w_g + 32'sd2048) >>> 12;
    assign w_cr_s = (32'sd2048 * w_r - 32'sd1715 * w_g - 32'sd333 * w_b + 32'sd2048) >>> 12;

    logic [15:0] w_eff_w, w_nbx, w_col, w_col_c;
    logic        w_mode_ok, w_mode444, w_zero_dim;
    logic        w_pix_take, w_row_end, w_last_line, w_strip_end;
    logic        w_adv, w_rd_en, w_wr_en, w_last_iss, w_emit_done;
    logic [2:0]  w_row;
    logic [7:0]  w_sel;
    logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;

    assign w_eff_w     = (img_width_i > LP_MAXW) ? LP_MAXW : img_width_i;
    assign w_nbx       = 16'((17'(w_eff_w) + 17'd7) >> 3);
    assign w_mode_ok   = ~img_mode_i[1];
    assign w_mode444   = (img_mode_i == 2'd1);
    assign w_zero_dim  = (img_width_i == 16'd0) || (img_height_i == 16'd0);

    assign w_pix_take  = (r_state == S_FILL) && r_accept && inport_valid_i;
    assign w_row_end   = (r_x == img_width_i - 16'd1);
    assign w_last_line = (r_y == img_height_i - 16'd1);
    assign w_strip_end = w_row_end && ((r_y[2:0] == 3'd7) || w_last_line);

    // Columns beyond the stored width are discarded at write time.
    assign w_wr_en   = rst_i && !img_start_i && w_pix_take && w_mode_ok && (r_x < LP_MAXW);
    assign w_wr_addr = ADDR_W'(r_y[2:0]) * LP_MAXW_A + ADDR_W'(r_x);

    // Edge padding: clamp column to W-1 and strip row to the last row written.
    assign w_col     = {r_bx[12:0], 3'b000} | {13'd0, r_idx[2:0]};
    assign w_col_c   = (w_col >= w_eff_w) ? (w_eff_w - 16'd1) : w_col;
    assign w_row     = (r_idx[5:3] > r_last_row) ? r_last_row : r_idx[5:3];
    assign w_rd_addr = ADDR_W'(w_row) * LP_MAXW_A + ADDR_W'(w_col_c);

    // The output register and the RAM stage advance together, so a steady
    // accept gives one beat per cycle; a stall freezes both (RAM read disabled).
    assign w_adv       = !r_out_valid || outport_accept_i;
    assign w_rd_en     = (r_state == S_EMIT) && w_adv && r_iss;
    assign w_last_iss  = (r_idx == 6'd63) && (r_comp == (w_mode444 ? 2'd2 : 2'd0))
                         && (r_bx == w_nbx - 16'd1);
    assign w_emit_done = (r_state == S_EMIT) && r_out_valid && outport_accept_i
                         && !r_p1_valid && !r_iss;

    always_comb begin
        w_sel = r_q[23:16];
        case (r_p1_comp)
            2'd1:    w_sel = r_q[15:8];
            2'd2:    w_sel = r_q[7:0];
            default: w_sel = r_q[23:16];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) r_mem[w_wr_addr] <= {sat8(w_y_s), sat8(w_cb_s), sat8(w_cr_s)};
        if (w_rd_en) r_q <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i || img_start_i) begin
            r_state      <= (!rst_i) ? S_IDLE : S_FILL;
            r_accept     <= rst_i && !w_zero_dim;
            r_idle       <= !rst_i;
            r_out_valid  <= 1'b0;
            r_out_data   <= 32'd0;
            r_out_idx    <= 6'd0;
            r_out_id     <= 32'd0;
            r_x          <= 16'd0;
            r_y          <= 16'd0;
            r_last_row   <= 3'd0;
            r_strip      <= 14'd0;
            r_last_strip <= 1'b0;
            r_bx         <= 16'd0;
            r_comp       <= 2'd0;
            r_idx        <= 6'd0;
            r_iss        <= 1'b0;
            r_p1_valid   <= 1'b0;
            r_p1_comp    <= 2'd0;
            r_p1_idx     <= 6'd0;
            r_p1_bx      <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: r_accept <= 1'b0;
                S_FILL: begin
                    if (w_zero_dim) begin
                        r_state     <= S_EOF;
                        r_accept    <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= 32'd0;
                        r_out_idx   <= 6'd0;
                        r_out_id    <= {2'd3, 30'd0};
                    end else if (w_pix_take) begin
                        if (w_row_end) begin
                            r_x <= 16'd0;
                            r_y <= r_y + 16'd1;
                        end else begin
                            r_x <= r_x + 16'd1;
                        end
                        if (!w_mode_ok) begin
                            if (w_row_end && w_last_line) begin
                                r_state     <= S_EOF;
                                r_accept    <= 1'b0;
                                r_out_valid <= 1'b1;
                                r_out_data  <= 32'd0;
                                r_out_idx   <= 6'd0;
                                r_out_id    <= {2'd3, 30'd0};
                            end
                        end else if (w_strip_end) begin
                            r_state      <= S_EMIT;
                            r_accept     <= 1'b0;
                            r_last_row   <= r_y[2:0];
                            r_strip      <= 14'(r_y >> 3);
                            r_last_strip <= w_last_line;
                            r_bx         <= 16'd0;
                            r_comp       <= 2'd0;
                            r_idx        <= 6'd0;
                            r_iss        <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_adv) begin
                        r_out_valid <= r_p1_valid;
                        if (r_p1_valid) begin
                            r_out_data <= {{24{w_sel[7]}}, w_sel};
                            r_out_idx  <= r_p1_idx;
                            r_out_id   <= {r_p1_comp, r_strip, r_p1_bx};
                        end
                        r_p1_valid <= r_iss;
                        if (r_iss) begin
                            r_p1_comp <= r_comp;
                            r_p1_idx  <= r_idx;
                            r_p1_bx   <= r_bx;
                            if (w_last_iss) r_iss <= 1'b0;
                            if (r_idx == 6'd63) begin
                                r_idx <= 6'd0;
                                if (w_mode444 && (r_comp != 2'd2)) begin
                                    r_comp <= r_comp + 2'd1;
                                end else begin
                                    r_comp <= 2'd0;
                                    r_bx   <= r_bx + 16'd1;
                                end
                            end else begin
                                r_idx <= r_idx + 6'd1;
                            end
                        end
                    end
                    if (w_emit_done) begin
                        if (r_last_strip) begin
                            r_state     <= S_EOF;
                            r_out_valid <= 1'b1;
                            r_out_data  <= 32'd0;
                            r_out_idx   <= 6'd0;
                            r_out_id    <= {2'd3, 30'd0};
                        end else begin
                            r_state  <= S_FILL;
                            r_accept <= 1'b1;
                        end
                    end
                end
                S_EOF: begin
                    if (outport_accept_i) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_id    <= 32'd0;
                        r_idle      <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign inport_accept_o = r_accept;
    assign outport_valid_o = r_out_valid;
    assign outport_data_o  = r_out_data;
    assign outport_idx_o   = r_out_idx;
    assign outport_id_o    = r_out_id;
    assign idle_o          = r_idle;

endmodule

// File: tb/tb_jpeg_input.sv
// Bench for jpeg_input: random pixel images, expected beats from a block-level model.
module tb_jpeg_input;
    localparam int MAXW = 16;
    localparam int AW   = 7;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        img_start_i = 1'b0;
    logic [15:0] img_width_i = '0, img_height_i = '0;
    logic [1:0]  img_mode_i = '0;
    logic        inport_valid_i = 1'b0;
    logic [7:0]  inport_r_i = '0, inport_g_i = '0, inport_b_i = '0;
    logic        inport_accept_o;
    logic        outport_valid_o;
    logic [31:0] outport_data_o;
    logic [5:0]  outport_idx_o;
    logic [31:0] outport_id_o;
    logic        outport_accept_i = 1'b0;
    logic        idle_o;

    always #5 clk = ~clk;

    jpeg_input #(.MAX_WIDTH(MAXW), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst_i), .img_start_i(img_start_i),
        .img_width_i(img_width_i), .img_height_i(img_height_i), .img_mode_i(img_mode_i),
        .inport_valid_i(inport_valid_i), .inport_r_i(inport_r_i), .inport_g_i(inport_g_i),
        .inport_b_i(inport_b_i), .inport_accept_o(inport_accept_o),
        .outport_valid_o(outport_valid_o), .outport_data_o(outport_data_o),
        .outport_idx_o(outport_idx_o), .outport_id_o(outport_id_o),
        .outport_accept_i(outport_accept_i), .idle_o(idle_o)
    );

    typedef struct {
        logic [31:0] data;
        logic [5:0]  idx;
        logic [31:0] id;
        bit          last;
    } beat_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    pr [512];
    int    pg [512];
    int    pb [512];
    beat_t exp_q [$];
    int    cur_w, cur_h, cur_mode;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int conv(int r, int g, int b, int c);
        int v;
        case (c)
            0:       v = ((1225*r + 2404*g + 467*b + 2048) >>> 12) - 128;
            1:       v = (-691*r - 1357*g + 2048*b + 2048) >>> 12;
            default: v = (2048*r - 1715*g - 333*b + 2048) >>> 12;
        endcase
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    // Expected beat list: strips, then block columns, then components, then raster idx.
    task automatic build_expected(int w, int h, int mode);
        beat_t e;
        int ew, nbx, nby, ncomp, row, col, p;
        exp_q.delete();
        if (mode < 2 && w > 0 && h > 0) begin
            ew    = (w > MAXW) ? MAXW : w;
            nbx   = (ew + 7) / 8;
            nby   = (h + 7) / 8;
            ncomp = (mode == 1) ? 3 : 1;
            for (int s = 0; s < nby; s++)
                for (int bx = 0; bx < nbx; bx++)
                    for (int c = 0; c < ncomp; c++)
                        for (int i = 0; i < 64; i++) begin
                            row = s*8 + i/8;
                            if (row > h-1) row = h-1;
                            col = bx*8 + i%8;
                            if (col > ew-1) col = ew-1;
                            p = row*w + col;
                            e.data = 32'(conv(pr[p], pg[p], pb[p], c));
                            e.idx  = 6'(i);
                            e.id   = (32'(c) << 30) | (32'(s) << 16) | 32'(bx);
                            e.last = (bx == nbx-1) && (c == ncomp-1) && (i == 63);
                            exp_q.push_back(e);
                        end
        end
        e.data = 32'd0; e.idx = 6'd0; e.id = {2'd3, 30'd0}; e.last = 1'b1;
        exp_q.push_back(e);
    endtask

    // kind: 0 white, 1 red, 2 random, 3 ramp (w = row length)
    task automatic fill_pixels(int kind, int w);
        int base;
        base = int'($urandom_range(0, 60));
        for (int k = 0; k < 512; k++) begin
            case (kind)
                0: begin pr[k] = 255; pg[k] = 255; pb[k] = 255; end
                1: begin pr[k] = 255; pg[k] = 0;   pb[k] = 0;   end
                3: begin
                    pr[k] = (base + (k % w) * 19) % 256;
                    pg[k] = (base + (k / w) * 23) % 256;
                    pb[k] = ((k % w) * 7 + (k / w) * 11) % 256;
                end
                default: begin
                    pr[k] = int'($urandom_range(0, 255));
                    pg[k] = int'($urandom_range(0, 255));
                    pb[k] = int'($urandom_range(0, 255));
                end
            endcase
        end
    endtask

    function automatic bit is_strip_end(int k);
        int px, py;
        if (cur_mode >= 2 || cur_w == 0 || cur_h == 0) return 1'b0;
        px = k % cur_w;
        py = k / cur_w;
        return (px == cur_w-1) && ((py % 8 == 7) || (py == cur_h-1));
    endfunction

    task automatic start_image(int w, int h, int mode);
        cur_w = w; cur_h = h; cur_mode = mode;
        inport_valid_i = 1'b0;
        img_width_i    = 16'(w);
        img_height_i   = 16'(h);
        img_mode_i     = 2'(mode);
        img_start_i    = 1'b1;
        @(negedge clk);
        img_start_i = 1'b0;
        chk("idle_after_start", idle_o, 1'b0);
    endtask

    // Runs from a negedge: drives pixels, collects beats, checks them in order.
    task automatic run_body(int stall, int abort_at, int n_supply, int n_exp_acc);
        int k, beats, cyc, lat;
        bit wait_first, held, chk_bub, done, acc;
        logic [70:0] held_val;
        beat_t e;
        k = 0; beats = 0; cyc = 0; lat = 0;
        wait_first = 0; held = 0; chk_bub = 0; done = 0;
        held_val = '0;
        while (!done && cyc < 20000) begin
            if (held)
                chk("hold_stable", {outport_valid_o, outport_data_o, outport_idx_o, outport_id_o}, held_val);
            if (chk_bub) begin
                chk("no_bubble", outport_valid_o, 1'b1);
                chk_bub = 0;
            end
            if (wait_first) begin
                lat++;
                if (outport_valid_o || lat > 2) begin
                    chk("first_beat_latency", lat <= 2, 1'b1);
                    wait_first = 0;
                end
            end
            if (abort_at > 0 && beats == abort_at && outport_valid_o) begin
                outport_accept_i = 1'b1;
                return;
            end
            acc = (stall != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
            outport_accept_i = acc;
            held = 0;
            if (outport_valid_o) begin
                if (acc) begin
                    chk("beat_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("beat", {outport_data_o, outport_idx_o, outport_id_o}, {e.data, e.idx, e.id});
                        chk_bub = (stall == 0) && !e.last;
                    end
                    beats++;
                    done = (outport_id_o[31:30] == 2'd3);
                end else begin
                    held = 1;
                    held_val = {outport_valid_o, outport_data_o, outport_idx_o, outport_id_o};
                end
            end
            if (k < n_supply && $urandom_range(0, 3) != 0) begin
                inport_valid_i = 1'b1;
                inport_r_i = 8'(pr[k]);
                inport_g_i = 8'(pg[k]);
                inport_b_i = 8'(pb[k]);
            end else begin
                inport_valid_i = 1'b0;
            end
            if (inport_valid_i && inport_accept_o) begin
                if (is_strip_end(k)) begin
                    wait_first = 1;
                    lat = -1;
                end
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        inport_valid_i = 1'b0;
        chk("eof_reached", done, 1'b1);
        chk("idle_after_eof", {idle_o, outport_valid_o}, 2'b10);
        chk("pixels_accepted", k, n_exp_acc);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", outport_valid_o, 1'b0);
        chk("rst_data", outport_data_o, 32'd0);
        chk("rst_idx", outport_idx_o, 6'd0);
        chk("rst_id", outport_id_o, 32'd0);
        chk("rst_accept", inport_accept_o, 1'b0);
        chk("rst_idle", idle_o, 1'b1);
        rst_i = 1'b1;
        @(negedge clk);

        // mono 8x8 white
        fill_pixels(0, 8); build_expected(8, 8, 0);
        start_image(8, 8, 0); run_body(0, 0, 68, 64);

        // 444 8x8 pure red
        fill_pixels(1, 8); build_expected(8, 8, 1);
        start_image(8, 8, 1); run_body(0, 0, 68, 64);

        // mono 10x9 ramp: padded columns and rows
        fill_pixels(3, 10); build_expected(10, 9, 0);
        start_image(10, 9, 0); run_body(0, 0, 94, 90);

        // 444 16x8 random with random downstream stalls
        fill_pixels(2, 16); build_expected(16, 8, 1);
        start_image(16, 8, 1); run_body(1, 0, 132, 128);

        // mono 20x8: columns past MAX_WIDTH accepted and discarded
        fill_pixels(2, 20); build_expected(20, 8, 0);
        start_image(20, 8, 0); run_body(0, 0, 164, 160);

        // abort mid-EMIT, then a fresh image
        fill_pixels(2, 16); build_expected(16, 16, 1);
        start_image(16, 16, 1); run_body(0, 100, 260, 256);
        fill_pixels(2, 8); build_expected(8, 8, 0);
        start_image(8, 8, 0);
        chk("abort_valid_low", outport_valid_o, 1'b0);
        chk("abort_accept_high", inport_accept_o, 1'b1);
        run_body(0, 0, 68, 64);

        // zero width: nothing accepted, EOF only
        build_expected(0, 5, 0);
        start_image(0, 5, 0); run_body(0, 0, 4, 0);

        // reset in the middle of FILL
        fill_pixels(2, 8);
        start_image(8, 8, 1);
        for (int i = 0; i < 20; i++) begin
            inport_valid_i = 1'b1;
            inport_r_i = 8'(pr[i]); inport_g_i = 8'(pg[i]); inport_b_i = 8'(pb[i]);
            @(negedge clk);
        end
        rst_i = 1'b0;
        inport_valid_i = 1'b0;
        @(negedge clk);
        chk("midrst_valid", outport_valid_o, 1'b0);
        chk("midrst_accept", inport_accept_o, 1'b0);
        chk("midrst_idle", idle_o, 1'b1);
        chk("midrst_out", {outport_data_o, outport_idx_o, outport_id_o}, 70'd0);
        rst_i = 1'b1;
        @(negedge clk);

        // unsupported mode 3, 4x4: 16 pixels swallowed, EOF only
        fill_pixels(2, 4); build_expected(4, 4, 3);
        start_image(4, 4, 3); run_body(0, 0, 20, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
